// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared types and constants for the stopwatch control front-end.
//   state_t       : FSM state encoding (IDLE=00, RUN=01, PAUSE=10)
//   DEF_DIV       : default clk cycles per 100 Hz count strobe (50 MHz clock)
//   DEF_DB_CYCLES : default debounce length in clk samples (20 ms)
//   cnt_width()   : bits needed for a counter running 0..n-1 (minimum 1)
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    localparam int DEF_DIV       = 500000;
    localparam int DEF_DB_CYCLES = 1000000;

    // Width of a counter that must hold the values 0..n-1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchroniser, stable-level debouncer and press-pulse generator for
// one raw push-button.
//   clk      : system clock
//   rstn     : asynchronous active-low reset
//   btn_raw  : raw button level, asynchronous to clk
//   press_o  : one-cycle pulse on each accepted rising edge of the button
// A level change is accepted only after DB_CYCLES consecutive samples that
// differ from the current debounced level; shorter glitches are invisible.
// -----------------------------------------------------------------------------
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic rstn,
    input  logic btn_raw,
    output logic press_o
);

    localparam int             CW       = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_ZERO = CW'(0);

    logic          sync_meta_r;
    logic          sync_r;
    logic          level_r;
    logic          level_d_r;
    logic          press_r;
    logic [CW-1:0] cnt_r;

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_meta_r <= 1'b0;
            sync_r      <= 1'b0;
        end else begin
            sync_meta_r <= btn_raw;
            sync_r      <= sync_meta_r;
        end
    end

    // Debounce counter: counts consecutive differing samples, flips the level on the last one.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            level_r <= 1'b0;
            cnt_r   <= CNT_ZERO;
        end else if (sync_r != level_r) begin
            if (cnt_r == CNT_LAST) begin
                level_r <= sync_r;
                cnt_r   <= CNT_ZERO;
            end else begin
                level_r <= level_r;
                cnt_r   <= cnt_r + CNT_ONE;
            end
        end else begin
            level_r <= level_r;
            cnt_r   <= CNT_ZERO;
        end
    end

    // Registered rising-edge detect of the debounced level; releases give nothing.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            level_d_r <= 1'b0;
            press_r   <= 1'b0;
        end else begin
            level_d_r <= level_r;
            press_r   <= level_r & ~level_d_r;
        end
    end

    assign press_o = press_r;

endmodule

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
// Control front-end for the stopwatch counter: debounces the start/stop and
// reset buttons, runs the IDLE/RUN/PAUSE state machine and produces the
// count strobe.
//   clk         : system clock
//   rstn        : asynchronous active-low reset
//   btn_ss_i    : raw start/stop button (active-high, asynchronous)
//   btn_rst_i   : raw reset button (active-high, asynchronous)
//   tick_o      : one-cycle count strobe, only ever high in RUN
//   timer_en_o  : counter enable, high exactly while in RUN
//   timer_rst_o : one-cycle synchronous clear for the counter
//   state_o     : current FSM state (LEDs / debug)
// -----------------------------------------------------------------------------
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DIV       = DEF_DIV,
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       btn_ss_i,
    input  logic       btn_rst_i,
    output logic       tick_o,
    output logic       timer_en_o,
    output logic       timer_rst_o,
    output logic [1:0] state_o
);

    localparam int             DW       = cnt_width(DIV);
    localparam logic [DW-1:0]  DIV_LAST = DW'(DIV - 1);
    localparam logic [DW-1:0]  DIV_ONE  = DW'(1);
    localparam logic [DW-1:0]  DIV_ZERO = DW'(0);

    logic          ss_press_s;
    logic          rst_press_s;
    state_t        state_r;
    logic          timer_rst_r;
    logic [DW-1:0] div_r;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ss (
        .clk     (clk),
        .rstn    (rstn),
        .btn_raw (btn_ss_i),
        .press_o (ss_press_s)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_rst (
        .clk     (clk),
        .rstn    (rstn),
        .btn_raw (btn_rst_i),
        .press_o (rst_press_s)
    );

    // State machine with the registered counter-clear pulse.
    // In RUN start/stop has priority over reset; elsewhere reset wins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            timer_rst_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rst_press_s) begin
                        state_r     <= ST_IDLE;
                        timer_rst_r <= 1'b1;
                    end else if (ss_press_s) begin
                        state_r     <= ST_RUN;
                        timer_rst_r <= 1'b0;
                    end else begin
                        state_r     <= ST_IDLE;
                        timer_rst_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (ss_press_s) begin
                        state_r <= ST_PAUSE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                    timer_rst_r <= 1'b0;
                end
                ST_PAUSE: begin
                    if (rst_press_s) begin
                        state_r     <= ST_IDLE;
                        timer_rst_r <= 1'b1;
                    end else if (ss_press_s) begin
                        state_r     <= ST_RUN;
                        timer_rst_r <= 1'b0;
                    end else begin
                        state_r     <= ST_PAUSE;
                        timer_rst_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    timer_rst_r <= 1'b0;
                end
            endcase
        end
    end

    // Strobe divider: wraps in RUN, holds its phase in PAUSE, cleared otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_r <= DIV_ZERO;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (div_r == DIV_LAST) begin
                        div_r <= DIV_ZERO;
                    end else begin
                        div_r <= div_r + DIV_ONE;
                    end
                end
                ST_PAUSE: div_r <= div_r;
                default:  div_r <= DIV_ZERO;
            endcase
        end
    end

    // Outputs are pure decodes of flop outputs, so they change only on clock edges.
    assign tick_o      = (state_r == ST_RUN) && (div_r == DIV_LAST);
    assign timer_en_o  = (state_r == ST_RUN);
    assign timer_rst_o = timer_rst_r;
    assign state_o     = state_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
// Scoreboard bench for stopwatch_ctrl with DIV=5, DB_CYCLES=4.
// The stimulus process pushes hand-computed output events (cycle number plus
// all outputs) into ev_q, and output snapshots into snap_q. The monitor runs
// on the falling edge: every cycle where tick_o or timer_rst_o is high or
// state_o changes is an event that must match the head of ev_q; snapshots
// are compared on their scheduled cycle.
// cyc counts rising clock edges; a raw press driven just after rising edge c
// changes state on rising edge c+8 (2 sync + 4 debounce + 1 edge + 1 FSM).
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

    localparam int DIV = 5;
    localparam int DB  = 4;

    typedef struct {
        int         cyc;
        logic       tick;
        logic       en;
        logic       trst;
        logic [1:0] st;
    } ev_t;

    logic       clk;
    logic       rstn;
    logic       btn_ss_i;
    logic       btn_rst_i;
    logic       tick_o;
    logic       timer_en_o;
    logic       timer_rst_o;
    logic [1:0] state_o;

    ev_t  ev_q[$];
    ev_t  snap_q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    bit   done  = 1'b0;
    logic [1:0] prev_st = 2'b00;

    stopwatch_ctrl #(.DIV(DIV), .DB_CYCLES(DB)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .btn_ss_i    (btn_ss_i),
        .btn_rst_i   (btn_rst_i),
        .tick_o      (tick_o),
        .timer_en_o  (timer_en_o),
        .timer_rst_o (timer_rst_o),
        .state_o     (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at cyc=%0d, want run complete", cyc);
        $fatal(1, "watchdog");
    end

    task automatic exp_ev(input int c, input logic t, input logic e, input logic r, input logic [1:0] s);
        ev_t x;
        x.cyc = c; x.tick = t; x.en = e; x.trst = r; x.st = s;
        ev_q.push_back(x);
    endtask

    task automatic exp_snap(input int c, input logic t, input logic e, input logic r, input logic [1:0] s);
        ev_t x;
        x.cyc = c; x.tick = t; x.en = e; x.trst = r; x.st = s;
        snap_q.push_back(x);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raw press held for 'hold' cycles, starting just after the current rising edge.
    task automatic press(input bit ss, input bit rs, input int hold);
        if (ss) btn_ss_i = 1'b1;
        if (rs) btn_rst_i = 1'b1;
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        btn_ss_i  = 1'b0;
        btn_rst_i = 1'b0;
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        ev_t e;
        if (tick_o || timer_rst_o || (state_o != prev_st)) begin
            total++;
            if (ev_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: cyc=%0d tick=%0b en=%0b trst=%0b st=%0d, want no event",
                         cyc, tick_o, timer_en_o, timer_rst_o, state_o);
            end else begin
                e = ev_q.pop_front();
                if (e.cyc != cyc || e.tick !== tick_o || e.en !== timer_en_o ||
                    e.trst !== timer_rst_o || e.st !== state_o) begin
                    bad++;
                    $display("FAIL event: got cyc=%0d tick=%0b en=%0b trst=%0b st=%0d, want cyc=%0d tick=%0b en=%0b trst=%0b st=%0d",
                             cyc, tick_o, timer_en_o, timer_rst_o, state_o,
                             e.cyc, e.tick, e.en, e.trst, e.st);
                end
            end
        end
        prev_st = state_o;
        if (snap_q.size() > 0 && snap_q[0].cyc == cyc) begin
            e = snap_q.pop_front();
            total++;
            if (e.tick !== tick_o || e.en !== timer_en_o || e.trst !== timer_rst_o || e.st !== state_o) begin
                bad++;
                $display("FAIL snapshot: cyc=%0d got tick=%0b en=%0b trst=%0b st=%0d, want tick=%0b en=%0b trst=%0b st=%0d",
                         cyc, tick_o, timer_en_o, timer_rst_o, state_o, e.tick, e.en, e.trst, e.st);
            end
        end
        if (done) begin
            total++;
            if (ev_q.size() != 0 || snap_q.size() != 0) begin
                bad++;
                $display("FAIL leftover: got %0d events and %0d snapshots pending, want 0 and 0",
                         ev_q.size(), snap_q.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    // Directed stimulus with hand-computed expected events.
    initial begin
        int c0;
        int t;
        int r2;
        int r3;
        int r4;
        rstn      = 1'b0;
        btn_ss_i  = 1'b0;
        btn_rst_i = 1'b0;

        // 1. reset for 3 cycles, then idle 20 cycles with no output activity
        exp_snap(1, 1'b0, 1'b0, 1'b0, 2'b00);
        exp_snap(23, 1'b0, 1'b0, 1'b0, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        wait_to(25);

        // 2. 3-cycle glitch is invisible
        press(1'b1, 1'b0, 3);
        wait_to(45);

        // 2/3/4. clean 4-cycle press -> RUN 8 cycles later; ticks on RUN cycles 5,10,15,20;
        // pause so that 22 RUN cycles elapse (divider phase 2)
        c0 = cyc;
        t  = c0 + 8;
        exp_ev(t,      1'b0, 1'b1, 1'b0, 2'b01);
        exp_ev(t + 4,  1'b1, 1'b1, 1'b0, 2'b01);
        exp_ev(t + 9,  1'b1, 1'b1, 1'b0, 2'b01);
        exp_ev(t + 14, 1'b1, 1'b1, 1'b0, 2'b01);
        exp_ev(t + 19, 1'b1, 1'b1, 1'b0, 2'b01);
        exp_ev(t + 22, 1'b0, 1'b0, 1'b0, 2'b10);
        exp_snap(t + 23, 1'b0, 1'b0, 1'b0, 2'b10);
        press(1'b1, 1'b0, 4);
        wait_to(t + 14);
        press(1'b1, 1'b0, 4);
        wait_to(t + 52);       // 30 paused cycles without ticks

        // 4. resume: first tick on 3rd RUN cycle; 5. rst ignored in RUN,
        // rst in PAUSE -> IDLE with clear, rst in IDLE -> clear again
        c0 = cyc;
        r2 = c0 + 8;
        r3 = r2 + 53;
        r4 = r3 + 43;
        exp_ev(r2,      1'b0, 1'b1, 1'b0, 2'b01);
        exp_ev(r2 + 2,  1'b1, 1'b1, 1'b0, 2'b01);
        exp_ev(r2 + 7,  1'b1, 1'b1, 1'b0, 2'b01);
        exp_ev(r2 + 12, 1'b1, 1'b1, 1'b0, 2'b01);
        exp_ev(r2 + 17, 1'b1, 1'b1, 1'b0, 2'b01);
        exp_ev(r2 + 20, 1'b0, 1'b0, 1'b0, 2'b10);
        exp_ev(r2 + 29, 1'b0, 1'b0, 1'b1, 2'b00);
        exp_ev(r2 + 43, 1'b0, 1'b0, 1'b1, 2'b00);
        // divider was cleared: first tick on 5th RUN cycle again
        exp_ev(r3,      1'b0, 1'b1, 1'b0, 2'b01);
        exp_ev(r3 + 4,  1'b1, 1'b1, 1'b0, 2'b01);
        exp_ev(r3 + 9,  1'b1, 1'b1, 1'b0, 2'b01);
        // 6. simultaneous in RUN -> PAUSE, simultaneous in PAUSE -> IDLE + clear
        exp_ev(r3 + 13, 1'b0, 1'b0, 1'b0, 2'b10);
        exp_ev(r3 + 28, 1'b0, 1'b0, 1'b1, 2'b00);
        // 6. rstn mid-RUN: immediate return to IDLE, nothing on release
        exp_ev(r4,      1'b0, 1'b1, 1'b0, 2'b01);
        exp_ev(r4 + 4,  1'b1, 1'b1, 1'b0, 2'b01);
        exp_ev(r4 + 6,  1'b0, 1'b0, 1'b0, 2'b00);
        exp_snap(r4 + 7,  1'b0, 1'b0, 1'b0, 2'b00);
        exp_snap(r4 + 20, 1'b0, 1'b0, 1'b0, 2'b00);

        press(1'b1, 1'b0, 4);
        wait_to(r2 + 1);
        press(1'b0, 1'b1, 4);
        wait_to(r2 + 12);
        press(1'b1, 1'b0, 4);
        wait_to(r2 + 21);
        press(1'b0, 1'b1, 4);
        wait_to(r2 + 35);
        press(1'b0, 1'b1, 4);
        wait_to(r2 + 45);
        press(1'b1, 1'b0, 4);
        wait_to(r3 + 5);
        press(1'b1, 1'b1, 4);
        wait_to(r3 + 20);
        press(1'b1, 1'b1, 4);
        wait_to(r3 + 35);
        press(1'b1, 1'b0, 4);
        wait_to(r4 + 6);
        rstn = 1'b0;
        wait_to(r4 + 8);
        rstn = 1'b1;
        wait_to(r4 + 30);
        done = 1'b1;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control front-end for the stopwatch counter. It synchronises and debounces two raw push-buttons (start/stop and reset) and runs a run/pause/idle state machine. It also generates the 100 Hz single-cycle count strobe. Outputs drive the counter stage's strobe, enable and synchronous-clear inputs directly.

Parameters:
DIV, 500000, clk cycles per count strobe (50 MHz / 100 Hz); legal range >= 2
DB_CYCLES, 1000000, consecutive stable samples required to accept a button level change (20 ms); legal range >= 2

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
btn_ss_i  input  1  raw start/stop button, active-high, asynchronous to clk
btn_rst_i  input  1  raw reset button, active-high, asynchronous to clk
tick_o  output  1  one-cycle count strobe; feeds counter strobe input
timer_en_o  output  1  counter enable; high only in RUN
timer_rst_o  output  1  one-cycle synchronous clear for the counter
state_o  output  2  current FSM state, for LEDs/debug

Behaviour:
- Reset: clk and rstn as already decided (reset rstn, asynchronous, active-low; clock clk). All flops clear. tick_o=0, timer_en_o=0, timer_rst_o=0, state_o=IDLE (2'b00). Divider=0. Debounced levels=0.
- Synchroniser: 2-flop chain per button, reset value 0.
- Debounce, per button:
  - Counter increments while the synced level differs from the debounced level.
  - Counter clears to 0 whenever the levels are equal.
  - On the DB_CYCLES-th consecutive differing sample, the debounced level takes the synced value and the counter clears.
  - Any glitch shorter than DB_CYCLES samples is invisible.
- Press pulse: registered rising edge of the debounced level, exactly 1 cycle wide. Releases generate nothing.
- FSM states: IDLE=00, RUN=01, PAUSE=10; 11 is unreachable and recovers to IDLE next cycle.
  - IDLE: ss press -> RUN. rst press -> stay IDLE and pulse timer_rst_o.
  - RUN: ss press -> PAUSE. rst press ignored.
  - PAUSE: ss press -> RUN. rst press -> IDLE and pulse timer_rst_o.
  - Simultaneous ss+rst press, same cycle:
    - In RUN, ss wins -> PAUSE.
    - In PAUSE/IDLE, rst wins -> IDLE with timer_rst_o pulse; ss is dropped.
- State register updates on the clock edge after the press-pulse cycle.
- timer_rst_o is registered with that same transition, i.e. high during the first cycle in the new state, 1 cycle.
- timer_en_o = (state==RUN), decoded from the state register; no extra latency.
- Divider:
  - In RUN: counts 0..DIV-1 and wraps to 0.
  - In PAUSE: holds its value, so sub-tick phase is preserved across pause.
  - In IDLE: forced to 0.
- tick_o: high for exactly the one cycle in which state==RUN and divider==DIV-1. It is never high outside RUN.
  - The first tick after IDLE->RUN occurs on the DIV-th RUN cycle.
- Latency, clean raw press to state change: 2 (sync) + DB_CYCLES + 1 (edge reg) + 1 cycles.
- rstn asserted mid-operation: immediate return to reset values. No tick or timer_rst_o pulse is emitted on reset release.

Decomposition:
- Package stopwatch_pkg:
  - state typedef/localparams IDLE/RUN/PAUSE
  - default DIV and DB_CYCLES constants
  - helper for the counter width, $clog2 of the parameter
- Sub-module btn_debounce (synchroniser + debounce counter + press-pulse register, parameter DB_CYCLES), instantiated twice.
- FSM and divider stay in the top.

Test Plan:
All scenarios use DIV=5, DB_CYCLES=4.
1. rstn low 3 cycles then high, buttons idle 20 cycles -> state_o=00, tick_o/timer_en_o/timer_rst_o stay 0.
2. btn_ss_i high 3 clk cycles then low -> no press pulse, state_o stays 00; same at 4+ cycles -> state_o=01 exactly 2+4+1+1=8 cycles after the raw edge.
3. RUN for 20 cycles -> timer_en_o=1 throughout, tick_o high on RUN cycles 5,10,15,20 (4 pulses, each 1 cycle).
4. Pause after 7 RUN cycles (divider=2) -> state 10, timer_en_o=0, no ticks for 30 cycles. Resume -> first tick on the 3rd RUN cycle after re-entry.
5. btn_rst_i press in RUN -> ignored, ticks continue. Press in PAUSE -> state 00, timer_rst_o high exactly 1 cycle, divider 0. Press again in IDLE -> another 1-cycle timer_rst_o, state stays 00.
6. Simultaneous press in RUN -> PAUSE, no timer_rst_o. Simultaneous press in PAUSE -> IDLE with timer_rst_o pulse. rstn pulsed mid-RUN -> all outputs 0 immediately, no pulse on release.
